clink_arbiter: RTL
==================

// Module: clink_arbiter
// PURPOSE
// - Round-robin arbiter sharing one UMI output link between N clink_fifo read ports.
// - Sits in the umi_out_clk domain, directly downstream of N FIFO instances.
// - Drives a single registered valid/ready output: one word per cycle, fair interleave.
// PARAMETERS
// - N        4     number of requesting channels (>=2)
// - DW       256   UMI word width
// - TIMEOUT  1024  output stall limit in cycles (used only with CLINK_ARB_WATCHDOG_EN)
// PORTS
// - umi_out_clk     in   1     clock
// - umi_out_nreset  in   1     asynchronous active-low reset
// - enable          in   N     per-channel arbitration enable mask
// - in_valid        in   N     channel word valid
// - in_data         in   N*DW  channel words, channel i at [i*DW +: DW]
// - in_ready        out  N     channel word accepted (one-hot or zero)
// - out_valid       out  1     output word valid
// - out_data        out  DW    output word
// - out_ready       in   1     downstream accept
// - grant           out  N     registered one-hot: source channel of current out_data
// - stall_err       out  1     sticky watchdog flag
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, grant=0, stall_err=0, last-grant pointer=N-1 (ch0 first).
// - Output register is loadable when ~out_valid | out_ready.
// - When loadable: req = in_valid & enable. Winner = first set bit of req searching
//   from (ptr+1) mod N upward with wrap. If req==0, in_ready=0; output goes
//   out_valid=0 if out_ready consumed the word, else holds.
// - Handshakes:
//   - in_ready[w]=1 combinationally for the winner only; the word transfers the same cycle.
//   - Next cycle: out_data=in_data[w], out_valid=1, grant=onehot(w), ptr=w.
//   - Latency in->out is 1 cycle.
// - Hold: out_valid & ~out_ready -> out_data, grant, ptr frozen; all in_ready=0.
//   No word is dropped or duplicated.
// - Throughput: back-to-back transfer each cycle when out_ready=1.
// - Fairness: a continuously requesting enabled channel is served within N transfers.
// - Simultaneous events: consume and reload in the same cycle is legal; out_valid stays 1.
// - Enable mask:
//   - Sampled only at arbitration; clearing a bit never cancels the word already in the output register.
//   - Disabled channel sees in_ready=0.
// - ptr changes only on a transfer; idle cycles do not advance it.
// - Reset mid-operation: output word discarded, out_valid=0 immediately; FIFOs retain their data.
// - in_ready must not depend on in_valid of other channels' future cycles.
// - No combinational path out_ready->out_valid; path out_ready->in_ready permitted.
// CONFIGURATION
// - Macro CLINK_ARB_WATCHDOG_EN.
// - Defined:
//   - Counter (width clog2(TIMEOUT+1)) increments each cycle out_valid & ~out_ready; clears on transfer or when out_valid=0.
//   - Reaching TIMEOUT sets stall_err=1, sticky until reset.
//   - Counter saturates, no wrap.
//   - Arbitration unaffected.
// - Undefined: no counter logic; stall_err tied to 0.
// TESTING
// - Reset, all in_valid=1, enable=4'hF, out_ready=1 -> grants ch0,1,2,3,0,... one per cycle;
//   out_data equals source word one cycle after in_ready.
// - Only ch2 valid, out_ready=1 for 8 cycles -> 8 consecutive words from ch2, in_ready[2]=1 every cycle.
// - out_valid=1 from ch1, out_ready=0 for 5 cycles -> out_data/grant stable, in_ready=4'h0;
//   out_ready=1 -> next grant ch2 if valid.
// - enable=4'b1011, all valid -> sequence 0,1,3,0,1,3; in_ready[2] never asserted.
// - Reset asserted while out_valid=1 -> out_valid=0 same edge; after release first grant is ch0.
// - With CLINK_ARB_WATCHDOG_EN, TIMEOUT=16:
//   - out_ready=0 for 16 cycles with out_valid=1 -> stall_err=1 and stays 1 after out_ready=1.
//   - Stall of 15 cycles -> stall_err stays 0.

Source files
------------

// File: rtl/clink_arbiter.sv
// clink_arbiter: round-robin N:1 arbiter feeding one registered UMI output word per cycle.
// Define CLINK_ARB_WATCHDOG_EN to add the sticky output-stall watchdog (stall_err).
module clink_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic            umi_out_clk,
    input  logic            umi_out_nreset,
    input  logic [N-1:0]    enable,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic [N-1:0]    grant,
    output logic            stall_err
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [N-1:0]  req;
    logic          hit;
    logic          load;

    assign load = ~out_valid | out_ready;
    assign req  = in_valid & enable;

    // Search starts just past the last winner so every requester is reached within N transfers.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        win = ptr;
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!hit && req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    assign in_ready = (load && hit) ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;

    always_ff @(posedge umi_out_clk or negedge umi_out_nreset) begin
        if (!umi_out_nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= PW'(N - 1);
        end else if (load) begin
            out_valid <= hit;
            if (hit) begin
                out_data <= in_data[int'(win)*DW +: DW];
                grant    <= in_ready;
                ptr      <= win;
            end
        end
    end

`ifdef CLINK_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge umi_out_clk or negedge umi_out_nreset) begin
        if (!umi_out_nreset) begin
            cnt       <= '0;
            stall_err <= 1'b0;
        end else if (out_valid && !out_ready) begin
            if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT - 1)) stall_err <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign stall_err = 1'b0;
`endif
endmodule
